// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: burst/response encodings and FSM state types shared by the axi_ram_slave files
package axi_ram_pkg;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
endpackage

// File: rtl/axi_ram_slave_if.sv
// axi_ram_slave_if: AXI4 bus (no lock/cache/prot/qos/region) between a master and axi_ram_slave
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 9
);
  logic [ID_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
          arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_ram_addr_gen.sv
// axi_ram_addr_gen: per-channel burst address sequencer; WRAP windows only exist when AXI_RAM_WRAP_EN is defined
module axi_ram_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [7:0] len_in,
  input  logic [2:0] size_in,
  input  logic [1:0] burst_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0] len,
  output logic ok
);
  logic [2:0] size;
  logic [1:0] burst;
  logic [ADDR_WIDTH-1:0] src, inc, nxt;
  logic [2:0] src_size;
  logic [1:0] src_burst;
  // load and step together advance straight from the incoming address (read prefetch)
  assign src = load ? addr_in : addr;
  assign src_size = load ? size_in : size;
  assign src_burst = load ? burst_in : burst;
  assign inc = ADDR_WIDTH'(1) << src_size;
`ifdef AXI_RAM_WRAP_EN
  logic [7:0] src_len;
  logic [ADDR_WIDTH-1:0] mask;
  logic wrap_go;
  assign src_len = load ? len_in : len;
  assign mask = ((ADDR_WIDTH'(src_len) + ADDR_WIDTH'(1)) << src_size) - ADDR_WIDTH'(1);
  assign wrap_go = src_burst == WRAP && wrap_len_ok(src_len);
  assign nxt = src_burst == FIXED ? src : wrap_go ? (src & ~mask) | ((src + inc) & mask) : src + inc;
  assign ok = burst != WRAP || wrap_len_ok(len);
`else
  assign nxt = src_burst == FIXED ? src : src + inc;
  assign ok = burst != WRAP;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= FIXED;
    end else begin
      if (load) begin
        len <= len_in;
        size <= size_in;
        burst <= burst_in;
      end
      if (load || step) addr <= step ? nxt : addr_in;
    end
  end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 RAM endpoint with independent read/write burst FSMs and byte-enable writes.
// WRAP bursts are honoured only with AXI_RAM_WRAP_EN defined; otherwise they complete with SLVERR.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 9
) (
  input logic clk,
  input logic rst,
  axi_ram_slave_if.slave s_axi
);
  localparam int OFF = $clog2(STRB_WIDTH);
  localparam int WORD_W = ADDR_WIDTH - OFF;
  logic [DATA_WIDTH-1:0] mem [2**WORD_W];
  logic [DATA_WIDTH-1:0] rdata_q;
  wstate_t w_state, w_nxt;
  rstate_t r_state, r_nxt;
  logic live;
  logic [7:0] w_cnt, r_cnt, w_len, r_len;
  logic [ID_WIDTH-1:0] w_id, r_id;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr, fetch;
  logic w_ok, r_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last, r_last, r_step;
  axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) w_gen (
    .clk(clk), .rst(rst), .load(aw_hs), .step(w_hs),
    .addr_in(s_axi.awaddr), .len_in(s_axi.awlen), .size_in(s_axi.awsize), .burst_in(s_axi.awburst),
    .addr(w_addr), .len(w_len), .ok(w_ok)
  );
  // the read generator runs one beat ahead: it holds the address of the next word to fetch
  axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) r_gen (
    .clk(clk), .rst(rst), .load(ar_hs), .step(r_step),
    .addr_in(s_axi.araddr), .len_in(s_axi.arlen), .size_in(s_axi.arsize), .burst_in(s_axi.arburst),
    .addr(r_addr), .len(r_len), .ok(r_ok)
  );
  assign s_axi.awready = live && w_state == W_IDLE;
  assign s_axi.wready = w_state == W_DATA;
  assign s_axi.bvalid = w_state == W_RESP;
  assign s_axi.bid = w_id;
  assign s_axi.bresp = w_ok ? OKAY : SLVERR;
  assign s_axi.arready = live && r_state == R_IDLE;
  assign s_axi.rvalid = r_state == R_DATA;
  assign s_axi.rlast = r_last;
  assign s_axi.rid = r_id;
  assign s_axi.rresp = r_ok ? OKAY : SLVERR;
  assign s_axi.rdata = r_ok ? rdata_q : '0;
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs = s_axi.wvalid && s_axi.wready;
  assign b_hs = s_axi.bvalid && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs = s_axi.rvalid && s_axi.rready;
  assign w_last = w_cnt == w_len;
  assign r_last = r_state == R_DATA && r_cnt == r_len;
  assign r_step = ar_hs || (r_hs && !r_last);
  assign fetch = r_state == R_IDLE ? s_axi.araddr : r_addr;
  always_comb begin
    w_nxt = w_state;
    r_nxt = r_state;
    if (aw_hs) w_nxt = W_DATA;
    if (w_hs && w_last) w_nxt = W_RESP;
    if (b_hs) w_nxt = W_IDLE;
    if (ar_hs) r_nxt = R_DATA;
    if (r_hs && r_last) r_nxt = R_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_cnt <= '0;
      r_cnt <= '0;
      w_id <= '0;
      r_id <= '0;
    end else begin
      live <= 1'b1;
      w_state <= w_nxt;
      r_state <= r_nxt;
      w_cnt <= aw_hs ? 8'd0 : w_hs ? w_cnt + 8'd1 : w_cnt;
      r_cnt <= ar_hs ? 8'd0 : r_hs ? r_cnt + 8'd1 : r_cnt;
      if (aw_hs) w_id <= s_axi.awid;
      if (ar_hs) r_id <= s_axi.arid;
    end
  end
  always_ff @(posedge clk) begin
    if (w_hs && w_ok)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (s_axi.wstrb[i]) mem[WORD_W'(w_addr >> OFF)][8*i +: 8] <= s_axi.wdata[8*i +: 8];
  end
  // a same-cycle write to the fetched word is not visible here, so reads return old data
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (r_step) rdata_q <= mem[WORD_W'(fetch >> OFF)];
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed vector table plus reset, backpressure and mid-burst reset sequences
module tb_axi_ram_slave;
  import axi_ram_pkg::*;
  typedef logic [31:0] beats_t [4];
  typedef struct {
    logic [8:0] id;
    logic [11:0] waddr;
    logic [7:0] wlen;
    logic [1:0] wburst;
    logic [3:0] wstrb;
    beats_t wdata;
    logic [1:0] bresp;
    logic [11:0] raddr;
    logic [7:0] rlen;
    logic [1:0] rburst;
    beats_t rdata;
    logic [1:0] rresp;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [11];
  axi_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .STRB_WIDTH(4), .ID_WIDTH(9)) m ();
  axi_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .STRB_WIDTH(4), .ID_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .s_axi(m.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic axi_write(input logic [8:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input beats_t d,
                           input logic [1:0] resp, input int bstall);
    int t = 0;
    @(negedge clk);
    m.awid = id; m.awaddr = addr; m.awlen = len; m.awsize = 3'd2; m.awburst = burst; m.awvalid = 1;
    while (!m.awready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("awready", m.awready, 1);
    @(negedge clk);
    m.awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      m.wdata = d[b % 4]; m.wstrb = strb; m.wlast = b == int'(len); m.wvalid = 1;
      chk("wready", m.wready, 1);
      @(negedge clk);
    end
    m.wvalid = 0; m.wlast = 0;
    repeat (bstall) begin
      chk("bvalid_hold", m.bvalid, 1);
      chk("awready_in_resp", m.awready, 0);
      @(negedge clk);
    end
    chk("bvalid", m.bvalid, 1);
    chk("bid", m.bid, id);
    chk("bresp", m.bresp, resp);
    m.bready = 1;
    @(negedge clk);
    m.bready = 0;
    chk("bvalid_drop", m.bvalid, 0);
  endtask
  task automatic axi_read(input logic [8:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input beats_t d, input logic [1:0] resp,
                          input int stall_beat);
    int t = 0;
    @(negedge clk);
    m.arid = id; m.araddr = addr; m.arlen = len; m.arsize = 3'd2; m.arburst = burst; m.arvalid = 1;
    while (!m.arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("arready", m.arready, 1);
    @(negedge clk);
    m.arvalid = 0;
    m.rready = 1;
    for (int b = 0; b <= int'(len); b++) begin
      chk("rvalid", m.rvalid, 1);
      if (b == stall_beat) begin
        m.rready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("rdata_hold", m.rdata, d[b % 4]);
          chk("rlast_hold", m.rlast, b == int'(len));
        end
        m.rready = 1;
      end
      chk("rdata", m.rdata, d[b % 4]);
      chk("rlast", m.rlast, b == int'(len));
      chk("rid", m.rid, id);
      chk("rresp", m.rresp, resp);
      @(negedge clk);
    end
    m.rready = 0;
    chk("rvalid_drop", m.rvalid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    m.awid = 0; m.awaddr = 0; m.awlen = 0; m.awsize = 0; m.awburst = 0; m.awvalid = 0;
    m.wdata = 0; m.wstrb = 0; m.wlast = 0; m.wvalid = 0; m.bready = 0;
    m.arid = 0; m.araddr = 0; m.arlen = 0; m.arsize = 0; m.arburst = 0; m.arvalid = 0; m.rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", m.awready, 0);
    chk("rst_arready", m.arready, 0);
    chk("rst_wready", m.wready, 0);
    chk("rst_bvalid", m.bvalid, 0);
    chk("rst_rvalid", m.rvalid, 0);
    chk("rst_rlast", m.rlast, 0);
    chk("rst_bid", m.bid, 0);
    chk("rst_rid", m.rid, 0);
    chk("rst_rdata", m.rdata, 0);
    chk("rst_bresp", m.bresp, 0);
    chk("rst_rresp", m.rresp, 0);
    rst = 0;
    @(negedge clk);
    chk("awready_after_rst", m.awready, 1);
    chk("arready_after_rst", m.arready, 1);
    vecs[0] = '{9'h011, 12'h010, 8'd0, INCR, 4'hF, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, OKAY,
                12'h010, 8'd0, INCR, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, OKAY};
    vecs[1] = '{9'h1A5, 12'h100, 8'd3, INCR, 4'hF, '{32'h1, 32'h2, 32'h3, 32'h4}, OKAY,
                12'h100, 8'd3, INCR, '{32'h1, 32'h2, 32'h3, 32'h4}, OKAY};
    vecs[2] = '{9'h022, 12'h020, 8'd0, INCR, 4'hF, '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, OKAY,
                12'h020, 8'd0, INCR, '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, OKAY};
    vecs[3] = '{9'h033, 12'h020, 8'd0, INCR, 4'h1, '{32'h00000011, 32'h0, 32'h0, 32'h0}, OKAY,
                12'h020, 8'd0, INCR, '{32'hFFFFFF11, 32'h0, 32'h0, 32'h0}, OKAY};
    vecs[4] = '{9'h044, 12'h040, 8'd2, FIXED, 4'hF, '{32'h5, 32'h6, 32'h7, 32'h0}, OKAY,
                12'h100, 8'd2, FIXED, '{32'h1, 32'h1, 32'h1, 32'h0}, OKAY};
    vecs[5] = '{9'h055, 12'hFFC, 8'd1, INCR, 4'hF, '{32'hA1, 32'hA2, 32'h0, 32'h0}, OKAY,
                12'hFFC, 8'd1, INCR, '{32'hA1, 32'hA2, 32'h0, 32'h0}, OKAY};
    vecs[6] = '{9'h066, 12'h000, 8'd3, INCR, 4'hF, '{32'h10, 32'h11, 32'h12, 32'h13}, OKAY,
                12'h000, 8'd3, INCR, '{32'h10, 32'h11, 32'h12, 32'h13}, OKAY};
    vecs[7] = '{9'h077, 12'h008, 8'd3, WRAP, 4'hF, '{32'hA, 32'hB, 32'hC, 32'hD}, SLVERR,
                12'h000, 8'd3, INCR, '{32'h10, 32'h11, 32'h12, 32'h13}, OKAY};
    vecs[8] = '{9'h088, 12'h008, 8'd2, WRAP, 4'hF, '{32'h9, 32'h9, 32'h9, 32'h0}, SLVERR,
                12'h008, 8'd3, WRAP, '{32'h0, 32'h0, 32'h0, 32'h0}, SLVERR};
    vecs[9] = '{9'h099, 12'h300, 8'd0, INCR, 4'hF, '{32'h55, 32'h0, 32'h0, 32'h0}, OKAY,
                12'h008, 8'd2, WRAP, '{32'h0, 32'h0, 32'h0, 32'h0}, SLVERR};
    vecs[10] = '{9'h0AA, 12'h304, 8'd0, INCR, 4'hF, '{32'h66, 32'h0, 32'h0, 32'h0}, OKAY,
                 12'h000, 8'd3, INCR, '{32'h10, 32'h11, 32'h12, 32'h13}, OKAY};
`ifdef AXI_RAM_WRAP_EN
    vecs[7].bresp = OKAY;
    vecs[7].rdata = '{32'hC, 32'hD, 32'hA, 32'hB};
    vecs[8].rdata = '{32'hA, 32'hB, 32'hC, 32'hD};
    vecs[8].rresp = OKAY;
    vecs[10].rdata = '{32'hC, 32'hD, 32'hA, 32'hB};
`endif
    for (int i = 0; i < 11; i++) begin
      axi_write(vecs[i].id, vecs[i].waddr, vecs[i].wlen, vecs[i].wburst, vecs[i].wstrb, vecs[i].wdata, vecs[i].bresp, 0);
      axi_read(vecs[i].id, vecs[i].raddr, vecs[i].rlen, vecs[i].rburst, vecs[i].rdata, vecs[i].rresp, -1);
    end
    axi_read(9'h1A5, 12'h100, 8'd3, INCR, '{32'h1, 32'h2, 32'h3, 32'h4}, OKAY, 1);
    axi_read(9'h1A5, 12'h100, 8'd3, INCR, '{32'h1, 32'h2, 32'h3, 32'h4}, OKAY, 3);
    axi_write(9'h0AB, 12'h140, 8'd0, INCR, 4'hF, '{32'h12345678, 32'h0, 32'h0, 32'h0}, OKAY, 4);
    axi_read(9'h0AB, 12'h140, 8'd0, INCR, '{32'h12345678, 32'h0, 32'h0, 32'h0}, OKAY, -1);
    @(negedge clk);
    m.awid = 9'h0C1; m.awaddr = 12'h180; m.awlen = 8'd3; m.awsize = 3'd2; m.awburst = INCR; m.awvalid = 1;
    chk("mid_awready", m.awready, 1);
    @(negedge clk);
    m.awvalid = 0;
    m.wdata = 32'h1; m.wstrb = 4'hF; m.wvalid = 1;
    @(negedge clk);
    m.wdata = 32'h2;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_awready", m.awready, 0);
    chk("mid_rst_wready", m.wready, 0);
    chk("mid_rst_bvalid", m.bvalid, 0);
    chk("mid_rst_arready", m.arready, 0);
    chk("mid_rst_rvalid", m.rvalid, 0);
    rst = 0;
    m.wvalid = 0;
    @(negedge clk);
    chk("post_rst_awready", m.awready, 1);
    chk("post_rst_wready", m.wready, 0);
    axi_write(9'h0C3, 12'h180, 8'd0, INCR, 4'hF, '{32'h77, 32'h0, 32'h0, 32'h0}, OKAY, 0);
    axi_read(9'h0C3, 12'h180, 8'd0, INCR, '{32'h77, 32'h0, 32'h0, 32'h0}, OKAY, -1);
    axi_read(9'h0C4, 12'h100, 8'd0, INCR, '{32'h1, 32'h0, 32'h0, 32'h0}, OKAY, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
